result_display_sequencer: RTL

- Sequential controller that converts a signed-magnitude result (magnitude plus sign bit) from the multiplier/divider/square-root datapath into 7-segment patterns.
- Runs an iterative double-dabble (shift-add-3) binary-to-BCD conversion, one bit per clock.
- Encodes each BCD digit and the sign, then holds the patterns on the display until the next conversion.
- Sits between the arithmetic result registers and the board's 7-segment displays, and handshakes with the top-level control FSM via start/busy/done.

---
 rtl/result_display_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/result_display_sequencer.sv
// Sequential binary-to-BCD (shift-add-3) converter driving 7-segment patterns.
// Optional leading-zero blanking is enabled by defining RESULT_DISPLAY_LZB_EN.
module result_display_sequencer #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sign_in,
  input  logic [WIDTH-1:0]      value_in,
  output logic                  busy,
  output logic                  done,
  output logic [6:0]            seg_sign,
  output logic [7*DIGITS-1:0]   seg_digits
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam longint unsigned MaxVal = (64'd1 << WIDTH) - 64'd1;

  // The BCD register must be able to hold the largest magnitude.
  generate
    if (WIDTH < 2 || WIDTH > 63 || DIGITS < 1 || DIGITS > 19 ||
        pow10(DIGITS) <= MaxVal) begin : g_bad_cfg
      $error("result_display_sequencer: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q;
  logic                sign_q;
  logic                nz_q;
  logic [6:0]          seg_sign_q, seg_sign_d;
  logic [7*DIGITS-1:0] seg_digits_q, seg_digits_d;
  logic                last_iter;

  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int k = 0; k < DIGITS; k++) begin
      if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble step: adjust nibbles, then shift {bcd, shift} left.
  assign bcd_d     = BW'({dabble(bcd_q), shift_q[WIDTH-1]});
  assign shift_d   = {shift_q[WIDTH-2:0], 1'b0};
  assign last_iter = (state_q == S_CONV) && (cnt_q == CW'(1));

  // Segment patterns computed from the final BCD value of the last step.
  always_comb begin
`ifdef RESULT_DISPLAY_LZB_EN
    logic lit;
    lit = 1'b0;
`endif
    seg_digits_d = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef RESULT_DISPLAY_LZB_EN
      if (bcd_d[4*k +: 4] != 4'd0 || k == 0) lit = 1'b1;
      seg_digits_d[7*k +: 7] = lit ? enc(bcd_d[4*k +: 4]) : BLANK;
`else
      seg_digits_d[7*k +: 7] = enc(bcd_d[4*k +: 4]);
`endif
    end
    seg_sign_d = (sign_q && nz_q) ? MINUS : BLANK;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CONV;
      S_CONV:  if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_CONV:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture, iterate, and latch patterns on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      sign_q       <= 1'b0;
      nz_q         <= 1'b0;
      seg_sign_q   <= BLANK;
      seg_digits_q <= '1;
    end else if (state_q == S_IDLE && start) begin
      shift_q <= value_in;
      sign_q  <= sign_in;
      nz_q    <= |value_in;
      bcd_q   <= '0;
      cnt_q   <= CW'(WIDTH);
    end else if (state_q == S_CONV) begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_q - CW'(1);
      if (last_iter) begin
        seg_sign_q   <= seg_sign_d;
        seg_digits_q <= seg_digits_d;
      end
    end
  end

  assign seg_sign   = seg_sign_q;
  assign seg_digits = seg_digits_q;

endmodule
